mps_precharge_seq: RTL and testbench



---
 rtl/mps_precharge_seq.sv | 242 ++++++++++++++++++++++++
 tb/tb_mps_precharge_seq.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mps_precharge_seq.sv
// mps_precharge_seq: DC-link precharge and main-contactor sequencer.
// Drives the precharge relay, the main contactor (MC) and the discharge relay
// in a fixed order. PWM is permitted only once the DC link is charged and the
// MC is closed.
// Build option: define MPS_PRECHG_FB_CHECK_EN to enforce contactor
// aux-feedback checking. When it is undefined, the aux inputs are ignored and
// every contactor wait becomes a fixed T_FB dwell.
module mps_precharge_seq #(
    parameter int unsigned T_FB     = 200000,
    parameter int unsigned T_PRECHG = 400000000,
    parameter int unsigned T_DISCH  = 2000000000,
    parameter int unsigned N_STABLE = 2000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_on_req,
    input  logic        i_off_req,
    input  logic        i_intl,
    input  logic        i_fault_clr,
    input  logic [31:0] i_dc_v,
    input  logic [31:0] i_vth_prechg,
    input  logic [31:0] i_vth_disch,
    input  logic        i_fb_prechg,
    input  logic        i_fb_mc,
    output logic        o_prechg,
    output logic        o_mc,
    output logic        o_disch,
    output logic        o_pwm_permit,
    output logic [3:0]  o_state,
    output logic [3:0]  o_fault
);

    // state codes are visible on o_state and must not be renumbered
    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_PRECHG     = 4'd1;
    localparam logic [3:0] S_MC_CLOSE   = 4'd2;
    localparam logic [3:0] S_RELAY_OPEN = 4'd3;
    localparam logic [3:0] S_READY      = 4'd4;
    localparam logic [3:0] S_OPEN_MC    = 4'd5;
    localparam logic [3:0] S_DISCHARGE  = 4'd6;
    localparam logic [3:0] S_FAULT      = 4'd7;

    // first-fault codes reported on o_fault
    localparam logic [3:0] F_NONE    = 4'd0;
    localparam logic [3:0] F_PRE_FB  = 4'd1;
    localparam logic [3:0] F_PRE_TO  = 4'd2;
    localparam logic [3:0] F_MC_FB   = 4'd3;
    localparam logic [3:0] F_RLY_FB  = 4'd4;
    localparam logic [3:0] F_MC_LOSS = 4'd5;
    localparam logic [3:0] F_OPEN_FB = 4'd6;
    localparam logic [3:0] F_DIS_TO  = 4'd7;
    localparam logic [3:0] F_INTL    = 4'd8;

    // one shared timer, sized for the longest timeout so it never wraps
    localparam longint unsigned T_MAX_A = (T_FB > T_PRECHG) ? T_FB : T_PRECHG;
    localparam longint unsigned T_MAX   = (T_MAX_A > T_DISCH) ? T_MAX_A : T_DISCH;
    localparam int TW = (T_MAX < 1) ? 1 : $clog2(T_MAX + 1);
    localparam int SW = (N_STABLE < 1) ? 1 : $clog2(64'(N_STABLE) + 1);

    localparam logic [TW-1:0] T_FB_END  = TW'(T_FB);
    localparam logic [TW-1:0] T_PRE_END = TW'(T_PRECHG);
    localparam logic [TW-1:0] T_DIS_END = TW'(T_DISCH);
    localparam logic [SW-1:0] N_END     = SW'(N_STABLE);

    logic [3:0]    state;
    logic [3:0]    state_nx;
    logic [3:0]    flt_cause;
    logic [TW-1:0] timer;
    logic [SW-1:0] stab_cnt;

    logic dc_hi;
    logic dc_lo;
    logic fb_to;
    logic pre_to;
    logic dis_to;
    logic stable_done;

    // abstracted contactor events; their meaning depends on the build option
    logic mc_closed;
    logic prechg_open;
    logic mc_open;
    logic wait_expired;
    logic prechg_fb_bad;
    logic mc_lost;

    assign o_state     = state;
    assign dc_hi       = (i_dc_v >= i_vth_prechg);
    assign dc_lo       = (i_dc_v < i_vth_disch);
    assign fb_to       = (timer == T_FB_END);
    assign pre_to      = (timer == T_PRE_END);
    assign dis_to      = (timer == T_DIS_END);
    assign stable_done = (stab_cnt == N_END);

`ifdef MPS_PRECHG_FB_CHECK_EN
    // Each wait ends on the aux contact; reaching T_FB without it is a fault.
    assign mc_closed     = i_fb_mc;
    assign prechg_open   = ~i_fb_prechg;
    assign mc_open       = ~i_fb_mc;
    assign wait_expired  = fb_to;
    assign prechg_fb_bad = fb_to & ~i_fb_prechg;
    assign mc_lost       = ~i_fb_mc;
`else
    // Aux contacts are not wired. Each wait is a blind T_FB dwell with no fault.
    logic unused_fb;
    assign unused_fb     = i_fb_prechg ^ i_fb_mc;
    assign mc_closed     = fb_to;
    assign prechg_open   = fb_to;
    assign mc_open       = fb_to;
    assign wait_expired  = 1'b0;
    assign prechg_fb_bad = 1'b0;
    assign mc_lost       = 1'b0;
`endif

    // Next-state selection. Priority: interlock > fault > off request > advance > on request.
    always_comb begin
        state_nx  = state;
        flt_cause = F_NONE;
        if (i_intl && (state != S_IDLE) && (state != S_FAULT)) begin
            state_nx  = S_FAULT;
            flt_cause = F_INTL;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_on_req && !i_intl && (o_fault == F_NONE))
                        state_nx = S_PRECHG;
                end
                S_PRECHG: begin
                    if (prechg_fb_bad) begin
                        state_nx  = S_FAULT;
                        flt_cause = F_PRE_FB;
                    end else if (pre_to) begin
                        state_nx  = S_FAULT;
                        flt_cause = F_PRE_TO;
                    end else if (i_off_req) begin
                        state_nx = S_OPEN_MC;
                    end else if (stable_done) begin
                        state_nx = S_MC_CLOSE;
                    end
                end
                S_MC_CLOSE: begin
                    if (wait_expired && !mc_closed) begin
                        state_nx  = S_FAULT;
                        flt_cause = F_MC_FB;
                    end else if (i_off_req) begin
                        state_nx = S_OPEN_MC;
                    end else if (mc_closed) begin
                        state_nx = S_RELAY_OPEN;
                    end
                end
                S_RELAY_OPEN: begin
                    if (wait_expired && !prechg_open) begin
                        state_nx  = S_FAULT;
                        flt_cause = F_RLY_FB;
                    end else if (i_off_req) begin
                        state_nx = S_OPEN_MC;
                    end else if (prechg_open) begin
                        state_nx = S_READY;
                    end
                end
                S_READY: begin
                    if (mc_lost) begin
                        state_nx  = S_FAULT;
                        flt_cause = F_MC_LOSS;
                    end else if (i_off_req) begin
                        state_nx = S_OPEN_MC;
                    end
                end
                S_OPEN_MC: begin
                    if (wait_expired && !mc_open) begin
                        state_nx  = S_FAULT;
                        flt_cause = F_OPEN_FB;
                    end else if (mc_open) begin
                        state_nx = S_DISCHARGE;
                    end
                end
                S_DISCHARGE: begin
                    if (dis_to) begin
                        state_nx  = S_FAULT;
                        flt_cause = F_DIS_TO;
                    end else if (dc_lo) begin
                        state_nx = S_IDLE;
                    end
                end
                S_FAULT: begin
                    if (i_fault_clr && !i_intl && dc_lo)
                        state_nx = S_IDLE;
                end
                // Unused codes park in FAULT with its safe drives. The clear path still works.
                default: state_nx = S_FAULT;
            endcase
        end
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Timer restarts on every state change and saturates instead of wrapping.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                 timer <= '0;
        else if (state_nx != state) timer <= '0;
        else if (timer != '1)       timer <= timer + 1'b1;
    end

    // Count consecutive above-threshold cycles in PRECHG. Any dip restarts the count.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)                                         stab_cnt <= '0;
        else if ((state_nx != state) || (state != S_PRECHG)) stab_cnt <= '0;
        else if (!dc_hi)                                    stab_cnt <= '0;
        else if (stab_cnt != N_END)                         stab_cnt <= stab_cnt + 1'b1;
    end

    // Latch only the first fault cause. It clears on the exit from FAULT to IDLE.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)
            o_fault <= F_NONE;
        else if ((state == S_FAULT) && (state_nx == S_IDLE))
            o_fault <= F_NONE;
        else if ((state_nx == S_FAULT) && (o_fault == F_NONE))
            o_fault <= flt_cause;
    end

    // Drives decode from the next state so they switch on the same edge as o_state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_prechg     <= 1'b0;
            o_mc         <= 1'b0;
            o_disch      <= 1'b1;
            o_pwm_permit <= 1'b0;
        end else begin
            o_prechg     <= (state_nx == S_PRECHG) || (state_nx == S_MC_CLOSE);
            o_mc         <= (state_nx == S_MC_CLOSE) || (state_nx == S_RELAY_OPEN) ||
                            (state_nx == S_READY);
            o_disch      <= (state_nx == S_IDLE) || (state_nx == S_DISCHARGE) ||
                            (state_nx == S_FAULT);
            o_pwm_permit <= (state_nx == S_READY);
        end
    end

endmodule

// File: tb/tb_mps_precharge_seq.sv
// Self-checking bench for mps_precharge_seq. Expected state timelines are
// derived from the sequencing rules (dwell times, stable-window search) with
// randomized voltage profiles and request timing.
module tb_mps_precharge_seq;

    localparam int T_FB     = 16;
    localparam int T_PRECHG = 1000;
    localparam int N_STABLE = 8;
    localparam int T_DISCH  = 1000;
`ifdef MPS_PRECHG_FB_CHECK_EN
    // aux contacts follow drives two cycles late; the wait ends one edge after that
    localparam int FB_DWELL = 3;
`else
    localparam int FB_DWELL = T_FB + 1;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_on_req = 1'b0;
    logic        i_off_req = 1'b0;
    logic        i_intl = 1'b0;
    logic        i_fault_clr = 1'b0;
    logic [31:0] i_dc_v = '0;
    logic [31:0] i_vth_prechg = 32'd500;
    logic [31:0] i_vth_disch = 32'd50;
    logic        i_fb_prechg;
    logic        i_fb_mc;
    logic        o_prechg;
    logic        o_mc;
    logic        o_disch;
    logic        o_pwm_permit;
    logic [3:0]  o_state;
    logic [3:0]  o_fault;
    logic [3:0]  drv;

    int checks = 0;
    int errors = 0;

    // plant model: aux contacts mirror the drives two cycles late
    logic [1:0] fbp_d = '0;
    logic [1:0] fbm_d = '0;
    logic       force_mc_open = 1'b0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        fbp_d <= {fbp_d[0], o_prechg};
        fbm_d <= {fbm_d[0], o_mc};
    end

    assign i_fb_prechg = fbp_d[1];
    assign i_fb_mc     = force_mc_open ? 1'b0 : fbm_d[1];
    assign drv         = {o_prechg, o_mc, o_disch, o_pwm_permit};

    mps_precharge_seq #(
        .T_FB(T_FB), .T_PRECHG(T_PRECHG), .T_DISCH(T_DISCH), .N_STABLE(N_STABLE)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_on_req(i_on_req), .i_off_req(i_off_req),
        .i_intl(i_intl), .i_fault_clr(i_fault_clr), .i_dc_v(i_dc_v),
        .i_vth_prechg(i_vth_prechg), .i_vth_disch(i_vth_disch),
        .i_fb_prechg(i_fb_prechg), .i_fb_mc(i_fb_mc),
        .o_prechg(o_prechg), .o_mc(o_mc), .o_disch(o_disch),
        .o_pwm_permit(o_pwm_permit), .o_state(o_state), .o_fault(o_fault)
    );

    // required drives per state: {prechg, mc, disch, pwm}
    function automatic logic [3:0] exp_drv(input logic [3:0] s);
        case (s)
            4'd1:    return 4'b1000;
            4'd2:    return 4'b1100;
            4'd3:    return 4'b0100;
            4'd4:    return 4'b0101;
            4'd5:    return 4'b0000;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_state(input logic [3:0] target, input int limit, input string tag);
        int n = 0;
        while (o_state !== target && n < limit) begin
            tick();
            n++;
        end
        checks++;
        if (o_state !== target) begin
            errors++;
            $display("FAIL %s: state %0d, wanted %0d within %0d cycles", tag, o_state, target, limit);
        end
    endtask

    task automatic go_ready(input string tag);
        i_dc_v = 32'd600;
        i_on_req = 1'b1; tick(); i_on_req = 1'b0;
        wait_state(4'd4, 200, tag);
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        repeat (3) tick();
        checks++;
        if (o_state !== 4'd0 || drv !== 4'b0010 || o_fault !== 4'd0) begin
            errors++;
            $display("FAIL reset_values: state %0d drv %b fault %0d, wanted 0 0010 0", o_state, drv, o_fault);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if (o_state !== 4'd0 || drv !== 4'b0010) begin
            errors++;
            $display("FAIL reset_release: state %0d drv %b, wanted 0 0010", o_state, drv);
        end
    endtask

    task automatic test_idle_ignore();
        i_intl = 1'b1;
        i_on_req = 1'b1; tick(); i_on_req = 1'b0;
        tick();
        checks++;
        if (o_state !== 4'd0 || o_fault !== 4'd0) begin
            errors++;
            $display("FAIL idle_on_with_intl: state %0d fault %0d, wanted 0 0", o_state, o_fault);
        end
        i_intl = 1'b0;
        i_off_req = 1'b1; tick(); i_off_req = 1'b0;
        checks++;
        if (o_state !== 4'd0 || drv !== 4'b0010) begin
            errors++;
            $display("FAIL idle_off_drop: state %0d drv %b, wanted 0 0010", o_state, drv);
        end
    endtask

    task automatic test_nominal_on();
        logic [31:0] seq[$];
        logic [3:0]  es;
        int d, g, c, run;
        d = $urandom_range(20, 0);
        g = $urandom_range(7, 0);
        for (int k = 0; k < d; k++) seq.push_back($urandom_range(499, 0));
        for (int k = 0; k < g; k++) seq.push_back($urandom_range(520, 500));
        seq.push_back($urandom_range(499, 0));
        for (int k = 0; k < 20; k++) seq.push_back($urandom_range(520, 500));
        // first cycle preceded by N_STABLE consecutive cycles at/above threshold
        c = -1; run = 0;
        for (int k = 0; k < seq.size() && c < 0; k++) begin
            if (run == N_STABLE) c = k;
            run = (seq[k] >= 32'd500) ? run + 1 : 0;
        end
        i_dc_v = 32'd0;
        i_on_req = 1'b1; tick(); i_on_req = 1'b0;
        checks++;
        if (o_state !== 4'd1 || drv !== exp_drv(4'd1)) begin
            errors++;
            $display("FAIL on_entry: state %0d drv %b, wanted 1 %b", o_state, drv, exp_drv(4'd1));
        end
        for (int k = 0; k <= c; k++) begin
            i_dc_v = seq[k];
            tick();
            es = (k == c) ? 4'd2 : 4'd1;
            checks++;
            if (o_state !== es || drv !== exp_drv(es)) begin
                errors++;
                $display("FAIL on_prechg cycle %0d: state %0d drv %b, wanted %0d %b", k, o_state, drv, es, exp_drv(es));
            end
        end
        i_dc_v = 32'd600;
        for (int j = 1; j <= 2 * FB_DWELL; j++) begin
            tick();
            es = (j < FB_DWELL) ? 4'd2 : (j < 2 * FB_DWELL) ? 4'd3 : 4'd4;
            checks++;
            if (o_state !== es || drv !== exp_drv(es)) begin
                errors++;
                $display("FAIL on_contactor step %0d: state %0d drv %b, wanted %0d %b", j, o_state, drv, es, exp_drv(es));
            end
        end
        checks++;
        if (o_pwm_permit !== 1'b1 || o_fault !== 4'd0) begin
            errors++;
            $display("FAIL on_ready: pwm %b fault %0d, wanted 1 0", o_pwm_permit, o_fault);
        end
    endtask

    task automatic test_nominal_off();
        logic [3:0] es;
        int f;
        i_off_req = 1'b1; tick(); i_off_req = 1'b0;
        checks++;
        if (o_state !== 4'd5 || drv !== 4'b0000) begin
            errors++;
            $display("FAIL off_entry: state %0d drv %b, wanted 5 0000", o_state, drv);
        end
        for (int j = 1; j <= FB_DWELL; j++) begin
            tick();
            es = (j < FB_DWELL) ? 4'd5 : 4'd6;
            checks++;
            if (o_state !== es || drv !== exp_drv(es)) begin
                errors++;
                $display("FAIL off_open_mc step %0d: state %0d drv %b, wanted %0d %b", j, o_state, drv, es, exp_drv(es));
            end
        end
        f = $urandom_range(30, 0);
        for (int k = 0; k <= f; k++) begin
            i_dc_v = (k < f) ? 32'($urandom_range(100, 50)) : 32'($urandom_range(49, 0));
            tick();
            es = (k == f) ? 4'd0 : 4'd6;
            checks++;
            if (o_state !== es || drv !== exp_drv(es)) begin
                errors++;
                $display("FAIL off_discharge cycle %0d: state %0d drv %b, wanted %0d %b", k, o_state, drv, es, exp_drv(es));
            end
        end
    endtask

    task automatic test_prechg_timeout();
        logic [3:0] es;
        int s;
        s = $urandom_range(100, 0);
        i_dc_v = 32'd499;
        i_on_req = 1'b1; tick(); i_on_req = 1'b0;
        for (int k = 0; k <= T_PRECHG; k++) begin
            i_dc_v = (k >= s && k < s + 7) ? 32'($urandom_range(520, 500)) : 32'd499;
            tick();
            es = (k == T_PRECHG) ? 4'd7 : 4'd1;
            checks++;
            if (o_state !== es) begin
                errors++;
                $display("FAIL prechg_timeout cycle %0d: state %0d, wanted %0d", k, o_state, es);
            end
        end
        checks++;
        if (o_fault !== 4'd2 || drv !== 4'b0010) begin
            errors++;
            $display("FAIL prechg_timeout_code: fault %0d drv %b, wanted 2 0010", o_fault, drv);
        end
        i_dc_v = 32'd40;
        i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
        checks++;
        if (o_state !== 4'd0 || o_fault !== 4'd0) begin
            errors++;
            $display("FAIL prechg_timeout_clear: state %0d fault %0d, wanted 0 0", o_state, o_fault);
        end
    endtask

    task automatic test_intl_fault();
        int r;
        i_dc_v = 32'd600;
        i_on_req = 1'b1; tick(); i_on_req = 1'b0;
        wait_state(4'd2, 50, "intl_reach_mc_close");
        r = $urandom_range(FB_DWELL - 2, 0);
        repeat (r) tick();
        i_intl = 1'b1; tick(); i_intl = 1'b0;
        checks++;
        if (o_state !== 4'd7 || o_fault !== 4'd8 || o_mc !== 1'b0 || drv !== 4'b0010) begin
            errors++;
            $display("FAIL intl_trip: state %0d fault %0d drv %b, wanted 7 8 0010", o_state, o_fault, drv);
        end
        i_dc_v = 32'd300;
        i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
        checks++;
        if (o_state !== 4'd7 || o_fault !== 4'd8) begin
            errors++;
            $display("FAIL clr_high_dc: state %0d fault %0d, wanted 7 8", o_state, o_fault);
        end
        i_dc_v = 32'd50;
        i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
        checks++;
        if (o_state !== 4'd7) begin
            errors++;
            $display("FAIL clr_at_threshold: state %0d, wanted 7", o_state);
        end
        i_dc_v = 32'd40;
        i_intl = 1'b1; i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0; i_intl = 1'b0;
        checks++;
        if (o_state !== 4'd7 || o_fault !== 4'd8) begin
            errors++;
            $display("FAIL clr_with_intl: state %0d fault %0d, wanted 7 8", o_state, o_fault);
        end
        i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
        checks++;
        if (o_state !== 4'd0 || o_fault !== 4'd0 || drv !== 4'b0010) begin
            errors++;
            $display("FAIL clr_ok: state %0d fault %0d drv %b, wanted 0 0 0010", o_state, o_fault, drv);
        end
    endtask

    task automatic test_off_intl_same();
        go_ready("same_reach_ready");
        i_off_req = 1'b1; i_intl = 1'b1; tick(); i_off_req = 1'b0; i_intl = 1'b0;
        checks++;
        if (o_state !== 4'd7 || o_fault !== 4'd8 || o_pwm_permit !== 1'b0) begin
            errors++;
            $display("FAIL off_intl_same: state %0d fault %0d pwm %b, wanted 7 8 0", o_state, o_fault, o_pwm_permit);
        end
        i_dc_v = 32'd40;
        i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL off_intl_clear: state %0d, wanted 0", o_state);
        end
    endtask

    task automatic test_drop_requests();
        go_ready("drop_reach_ready");
        i_on_req = 1'b1; tick(); i_on_req = 1'b0;
        repeat ($urandom_range(3, 0)) tick();
        checks++;
        if (o_state !== 4'd4 || drv !== 4'b0101) begin
            errors++;
            $display("FAIL ready_on_drop: state %0d drv %b, wanted 4 0101", o_state, drv);
        end
        i_dc_v = 32'd100;
        i_off_req = 1'b1; tick(); i_off_req = 1'b0;
        wait_state(4'd6, 40, "drop_reach_discharge");
        i_on_req = 1'b1; tick(); i_on_req = 1'b0;
        checks++;
        if (o_state !== 4'd6) begin
            errors++;
            $display("FAIL discharge_on_drop: state %0d, wanted 6", o_state);
        end
        i_dc_v = 32'd0;
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL discharge_done: state %0d, wanted 0", o_state);
        end
        i_on_req = 1'b1; tick(); i_on_req = 1'b0;
        i_off_req = 1'b1; tick(); i_off_req = 1'b0;
        checks++;
        if (o_state !== 4'd5 || drv !== 4'b0000) begin
            errors++;
            $display("FAIL prechg_off: state %0d drv %b, wanted 5 0000", o_state, drv);
        end
        wait_state(4'd0, 40, "prechg_off_to_idle");
    endtask

    task automatic test_disch_timeout();
        logic [3:0] es;
        go_ready("disch_reach_ready");
        i_dc_v = 32'd60;
        i_off_req = 1'b1; tick(); i_off_req = 1'b0;
        wait_state(4'd6, 40, "disch_reach_discharge");
        for (int k = 0; k <= T_DISCH; k++) begin
            tick();
            es = (k == T_DISCH) ? 4'd7 : 4'd6;
            checks++;
            if (o_state !== es) begin
                errors++;
                $display("FAIL disch_timeout cycle %0d: state %0d, wanted %0d", k, o_state, es);
            end
        end
        checks++;
        if (o_fault !== 4'd7) begin
            errors++;
            $display("FAIL disch_timeout_code: fault %0d, wanted 7", o_fault);
        end
        i_dc_v = 32'd40;
        i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
        wait_state(4'd0, 2, "disch_timeout_clear");
    endtask

`ifdef MPS_PRECHG_FB_CHECK_EN
    task automatic test_fb_loss();
        go_ready("fb_reach_ready");
        force_mc_open = 1'b1;
        tick();
        checks++;
        if (o_state !== 4'd7 || o_fault !== 4'd5 || o_pwm_permit !== 1'b0) begin
            errors++;
            $display("FAIL fb_loss: state %0d fault %0d pwm %b, wanted 7 5 0", o_state, o_fault, o_pwm_permit);
        end
        i_intl = 1'b1; tick(); tick();
        checks++;
        if (o_fault !== 4'd5) begin
            errors++;
            $display("FAIL fb_first_fault: fault %0d, wanted 5", o_fault);
        end
        i_intl = 1'b0; force_mc_open = 1'b0;
        i_dc_v = 32'd40;
        i_fault_clr = 1'b1; tick(); i_fault_clr = 1'b0;
        wait_state(4'd0, 2, "fb_loss_clear");
    endtask
`endif

    task automatic test_reset_mid();
        go_ready("rst_reach_ready");
        #1;
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_state !== 4'd0 || drv !== 4'b0010 || o_fault !== 4'd0) begin
            errors++;
            $display("FAIL reset_async: state %0d drv %b fault %0d, wanted 0 0010 0", o_state, drv, o_fault);
        end
        i_rst = 1'b1;
        tick();
        checks++;
        if (o_state !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_release: state %0d, wanted 0", o_state);
        end
    endtask

    initial begin
        test_reset();
        test_idle_ignore();
        test_nominal_on();
        test_nominal_off();
        test_prechg_timeout();
        test_intl_fault();
        test_off_intl_same();
        test_drop_requests();
        test_disch_timeout();
`ifdef MPS_PRECHG_FB_CHECK_EN
        test_fb_loss();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
